imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the single-cycle core reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive word addresses from BASE_ADDR and verifies an XOR checksum.
- Holds the core in its active-low reset until the load completes cleanly, then releases it with startPC = BASE_ADDR.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 71 +++++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and error codes for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE = 2'b00;
    localparam err_t ERR_LEN  = 2'b01;
    localparam err_t ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and issues one
// registered write strobe per completed word at consecutive word addresses.
module word_assembler #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_fire,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [15:0]       word_cnt
);

    logic [1:0]        idx_q, idx_d;
    logic [23:0]       lo_q, lo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    always_comb begin
        idx_d      = idx_q;
        lo_d       = lo_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        word_cnt_d = word_cnt_q;
        if (byte_fire) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0: lo_d[7:0]   = byte_in;
                2'd1: lo_d[15:8]  = byte_in;
                2'd2: lo_d[23:16] = byte_in;
                default: begin
                    // Word count doubles as the word index of the write being issued.
                    wr_en_d    = 1'b1;
                    wr_addr_d  = BASE_ADDR + (ADDR_W'(word_cnt_q) << 2);
                    wr_data_d  = {byte_in, lo_q};
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= 2'd0;
            lo_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into instruction-memory writes,
// verifies the XOR checksum and releases the core reset on a clean load.
//
// state  | meaning
// S_LEN0 | waiting for length low byte
// S_LEN1 | waiting for length high byte; range check
// S_DATA | receiving 4N payload bytes
// S_CSUM | waiting for checksum byte
// S_DONE | load good, core released (terminal)
// S_ERR  | length or checksum error, core held (terminal)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        byteIn,
    input  logic              byteValid,
    output logic              byteReady,
    output logic              imemWrEn,
    output logic [ADDR_W-1:0] imemWrAddr,
    output logic [31:0]       imemWrData,
    output logic              cpuResetN,
    output logic [ADDR_W-1:0] startPC,
    output logic [15:0]       wordsLoaded,
    output logic              loadDone,
    output logic [1:0]        loadError
);

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [17:0] rem_q, rem_d;
    logic [7:0]  csum_q, csum_d;
    err_t        err_q, err_d;
    logic        done_q, done_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;

    logic        byte_fire;
    logic        payload_fire;
    logic [15:0] n_words;

    assign byteReady    = !reset && (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
    assign byte_fire    = byteValid && byteReady;
    assign payload_fire = byte_fire && (state_q == S_DATA);
    assign n_words      = {byteIn, len_lo_q};

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        err_d       = err_q;
        done_d      = done_q;
        cpu_rst_n_d = cpu_rst_n_q;
        if (byte_fire) begin
            case (state_q)
                S_LEN0: begin
                    len_lo_d = byteIn;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    if ({16'd0, n_words} > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = ERR_LEN;
                    end else if (n_words == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                        rem_d   = {n_words, 2'b00};
                    end
                end
                S_DATA: begin
                    csum_d = csum_q ^ byteIn;
                    rem_d  = rem_q - 18'd1;
                    if (rem_q == 18'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    // Any final write was registered on the previous edge, so release follows it.
                    if (byteIn == csum_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_LEN0;
            len_lo_q    <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            err_q       <= ERR_NONE;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    word_assembler #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_word_assembler (
        .clk       (CLK),
        .reset     (reset),
        .byte_in   (byteIn),
        .byte_fire (payload_fire),
        .wr_en     (imemWrEn),
        .wr_addr   (imemWrAddr),
        .wr_data   (imemWrData),
        .word_cnt  (wordsLoaded)
    );

    assign startPC   = BASE_ADDR;
    assign cpuResetN = cpu_rst_n_q;
    assign loadDone  = done_q;
    assign loadError = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Drives framed byte streams into imem_loader and compares writes and status
// against a frame-level reference model.
module tb_imem_loader;

    localparam int MAXW = 256;

    logic        CLK;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        imemWrEn;
    logic [63:0] imemWrAddr;
    logic [31:0] imemWrData;
    logic        cpuResetN;
    logic [63:0] startPC;
    logic [15:0] wordsLoaded;
    logic        loadDone;
    logic [1:0]  loadError;

    imem_loader #(
        .ADDR_W    (64),
        .BASE_ADDR (64'h0),
        .MAX_WORDS (MAXW)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .byteIn      (byteIn),
        .byteValid   (byteValid),
        .byteReady   (byteReady),
        .imemWrEn    (imemWrEn),
        .imemWrAddr  (imemWrAddr),
        .imemWrData  (imemWrData),
        .cpuResetN   (cpuResetN),
        .startPC     (startPC),
        .wordsLoaded (wordsLoaded),
        .loadDone    (loadDone),
        .loadError   (loadError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // write log, sampled just after each rising edge
    logic [63:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [15:0] obs_wl[$];
    int          early_rel = 0;

    always @(posedge CLK) begin
        #1;
        if (imemWrEn) begin
            obs_addr.push_back(imemWrAddr);
            obs_data.push_back(imemWrData);
            obs_wl.push_back(wordsLoaded);
            if (cpuResetN) early_rel++;
        end
    end

    logic [7:0]  frame_q[$];
    logic [63:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic [1:0]  exp_err;
    int          exp_words;

    task automatic model_frame();
        int          n;
        logic [7:0]  cs;
        n = int'({frame_q[1], frame_q[0]});
        exp_addr.delete();
        exp_data.delete();
        cs = 8'h00;
        if (n > MAXW) begin
            exp_done  = 1'b0;
            exp_err   = 2'b01;
            exp_words = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(64'(i) * 64'd4);
                exp_data.push_back({frame_q[2+4*i+3], frame_q[2+4*i+2],
                                    frame_q[2+4*i+1], frame_q[2+4*i]});
                for (int k = 0; k < 4; k++) cs ^= frame_q[2+4*i+k];
            end
            exp_words = n;
            exp_done  = (frame_q[2+4*n] == cs);
            exp_err   = exp_done ? 2'b00 : 2'b10;
        end
    endtask

    // called at a falling edge; returns at the falling edge after the byte is taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        while (!byteReady && t < 8) begin
            @(negedge CLK);
            t++;
        end
        if (!byteReady) begin
            chk("ready_timeout", 64'(byteReady), 64'd1);
            return;
        end
        byteIn    = b;
        byteValid = 1'b1;
        @(negedge CLK);
        byteValid = 1'b0;
        byteIn    = 8'($urandom);
        repeat (gap) @(negedge CLK);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rdy_in_reset", 64'(byteReady), 64'd0);
        @(negedge CLK);
        chk("rst_wren", 64'(imemWrEn), 64'd0);
        chk("rst_addr", imemWrAddr, 64'd0);
        chk("rst_data", 64'(imemWrData), 64'd0);
        chk("rst_cpurst", 64'(cpuResetN), 64'd0);
        chk("rst_words", 64'(wordsLoaded), 64'd0);
        chk("rst_done", 64'(loadDone), 64'd0);
        chk("rst_err", 64'(loadError), 64'd0);
        reset = 1'b0;
        #1;
        chk("rdy_after_reset", 64'(byteReady), 64'd1);
    endtask

    function automatic int pick_gap(input int gap_mode);
        return (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
    endfunction

    task automatic run_frame(input string name, input int gap_mode, input int abort_after);
        int base;
        int er0;
        int nw;
        apply_reset();
        for (int i = 0; i < abort_after; i++) send_byte(frame_q[i], pick_gap(gap_mode));
        if (abort_after > 0) apply_reset();
        model_frame();
        base = obs_addr.size();
        er0  = early_rel;
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : pick_gap(gap_mode));
        chk({name, "_done"}, 64'(loadDone), 64'(exp_done));
        chk({name, "_err"}, 64'(loadError), 64'(exp_err));
        chk({name, "_cpurst"}, 64'(cpuResetN), 64'(exp_done));
        chk({name, "_ready"}, 64'(byteReady), 64'd0);
        chk({name, "_words"}, 64'(wordsLoaded), 64'(exp_words));
        chk({name, "_startpc"}, startPC, 64'd0);
        repeat (3) @(negedge CLK);
        nw = obs_addr.size() - base;
        chk({name, "_nwrites"}, 64'(nw), 64'(exp_addr.size()));
        for (int i = 0; i < nw && i < exp_addr.size(); i++) begin
            chk({name, "_waddr"}, obs_addr[base+i], exp_addr[i]);
            chk({name, "_wdata"}, 64'(obs_data[base+i]), 64'(exp_data[i]));
            chk({name, "_wcount"}, 64'(obs_wl[base+i]), 64'(i + 1));
        end
        chk({name, "_early_release"}, 64'(early_rel - er0), 64'd0);
        chk({name, "_done_sticky"}, 64'(loadDone), 64'(exp_done));
        chk({name, "_err_sticky"}, 64'(loadError), 64'(exp_err));
    endtask

    task automatic build_nominal(input logic [7:0] last);
        frame_q = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B,
                    8'h21, 8'h00, 8'h40, 8'hF8, last};
    endtask

    task automatic build_random(input int n, input bit good_csum);
        logic [7:0] cs;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n > MAXW) return;
        cs = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            frame_q.push_back(b);
        end
        if (!good_csum) cs ^= 8'(1 << $urandom_range(0, 7));
        frame_q.push_back(cs);
    endtask

    initial begin
        reset     = 1'b1;
        byteValid = 1'b0;
        byteIn    = 8'h00;
        repeat (2) @(negedge CLK);

        build_nominal(8'h30);
        run_frame("nominal", 0, 0);
        build_nominal(8'h31);
        run_frame("bad_csum", 0, 0);
        frame_q = '{8'h01, 8'h01};
        run_frame("oversize", 0, 0);
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", 0, 0);
        build_nominal(8'h30);
        run_frame("gapped", 3, 0);
        build_nominal(8'h30);
        run_frame("mid_reset", 3, 6);
        build_random(MAXW, 1'b1);
        run_frame("max_len", 0, 0);
        build_random(MAXW + 1, 1'b1);
        run_frame("max_len_p1", 0, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(MAXW + 1, 65535));
            build_random(n, $urandom_range(0, 3) != 0);
            run_frame("random", -1, (r % 5 == 4) ? int'($urandom_range(1, 5)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
